// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous ROM read port between two requesters, round-robin by default.
// Define ROM_ARB_FIXED_PRIO_EN to give requester 0 strict priority over requester 1.
module rom_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic              w_eff0;
    logic              w_eff1;
    logic              w_pick0;
    logic              w_pick1;

    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_last;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_tag1_v;
    logic              r_tag1_id;
    logic              r_tag2_v;
    logic              r_tag2_id;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid0;
    logic              r_rvalid1;

    // A requester is masked while its grant is high, so a one-cycle-late req drop never re-grants.
    assign w_eff0 = req0 & ~r_gnt0;
    assign w_eff1 = req1 & ~r_gnt1;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_pick1 = w_eff1 & ~w_eff0;
`else
    assign w_pick1 = w_eff1 & (~w_eff0 | ~r_last);
`endif
    assign w_pick0 = w_eff0 & ~w_pick1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_last     <= 1'b1;
            r_rom_addr <= '0;
            r_tag1_v   <= 1'b0;
            r_tag1_id  <= 1'b0;
            r_tag2_v   <= 1'b0;
            r_tag2_id  <= 1'b0;
            r_rdata    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_gnt0 <= w_pick0;
            r_gnt1 <= w_pick1;
            if (w_pick0 | w_pick1) begin
                r_rom_addr <= w_pick1 ? addr1 : addr0;
                r_last     <= w_pick1;
            end
            // Tag stage 2 lines up with the cycle the ROM output holds this grant's data.
            r_tag1_v  <= w_pick0 | w_pick1;
            r_tag1_id <= w_pick1;
            r_tag2_v  <= r_tag1_v;
            r_tag2_id <= r_tag1_id;
            r_rvalid0 <= r_tag2_v & ~r_tag2_id;
            r_rvalid1 <= r_tag2_v & r_tag2_id;
            if (r_tag2_v) begin
                r_rdata <= rom_data;
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = r_rdata;
    assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: randomized and directed stimulus against a transaction-level model.
// Build with ROM_ARB_FIXED_PRIO_EN defined to exercise the strict-priority variant.
module tb_rom_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam logic [DW-1:0] ROM_KEY = 12'hA5A;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    // Synchronous ROM: data for the address sampled at an edge appears after that edge.
    always @(posedge clk) rom_data <= rom_addr ^ ROM_KEY;

    // Reference model: a grant decision per edge plus a queue of pending returns due two edges later.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          exp_q[$];
    int            m_gnt;
    int            m_last;
    int            m_rv;
    int            cyc = 0;
    logic [DW-1:0] m_rdata;
    logic [3:0]    exp_flags;

    task automatic model_reset();
        m_gnt   = -1;
        m_last  = 1;
        m_rv    = -1;
        m_rdata = '0;
        exp_q.delete();
    endtask

    task automatic step();
        bit   e0;
        bit   e1;
        int   win;
        ret_t r;
        e0  = req0 && (m_gnt != 0);
        e1  = req1 && (m_gnt != 1);
        win = -1;
        if (e0 && e1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = (m_last == 0) ? 1 : 0;
`endif
        end else if (e0) begin
            win = 0;
        end else if (e1) begin
            win = 1;
        end
        cyc++;
        m_gnt = win;
        if (win >= 0) begin
            m_last = win;
            r.due  = cyc + 2;
            r.id   = win;
            r.data = (win == 1) ? (addr1 ^ ROM_KEY) : (addr0 ^ ROM_KEY);
            exp_q.push_back(r);
        end
        m_rv = -1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_rv    = exp_q[0].id;
            m_rdata = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        exp_flags = {m_gnt == 0, m_gnt == 1, m_rv == 0, m_rv == 1};
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 12'h111;
        addr1 = 12'h222;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1, rdata, rom_addr} !== '0) begin
                bad++;
                $display("FAIL reset_outputs got=%b_%b_%b_%b_%h_%h exp=all zero",
                         gnt0, gnt1, rvalid0, rvalid1, rdata, rom_addr);
            end
        end
        rst = 1'b1;
        step();
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_gnt got gnt0=%b gnt1=%b exp gnt0=1 gnt1=0", gnt0, gnt1);
        end
        total++;
        if (rom_addr !== 12'h111) begin
            bad++;
            $display("FAIL reset_first_addr got=%h exp=111", rom_addr);
        end
        step();
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_second_gnt got gnt0=%b gnt1=%b exp gnt0=0 gnt1=1", gnt0, gnt1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) begin
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL reset_drain got flags=%b rdata=%h exp flags=%b rdata=%h",
                         {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
        end
    endtask

    task automatic test_single_read();
        bit seen;
        seen  = 1'b0;
        req0  = 1'b1;
        addr0 = 12'h123;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags) begin
                bad++;
                $display("FAIL single_flags got=%b exp=%b", {gnt0, gnt1, rvalid0, rvalid1}, exp_flags);
            end
            seen = gnt0;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL single_timeout got gnt0=0 exp gnt0=1 within 8 cycles");
        end
        req0 = 1'b0;
        step();
        total++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL single_early got rvalid0=%b rvalid1=%b exp 0 0", rvalid0, rvalid1);
        end
        step();
        total++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== (12'h123 ^ ROM_KEY)) begin
            bad++;
            $display("FAIL single_return got rvalid0=%b rvalid1=%b rdata=%h exp 1 0 %h",
                     rvalid0, rvalid1, rdata, 12'h123 ^ ROM_KEY);
        end
        step();
        total++;
        if (rvalid0 !== 1'b0 || rdata !== m_rdata) begin
            bad++;
            $display("FAIL single_hold got rvalid0=%b rdata=%h exp 0 %h", rvalid0, rdata, m_rdata);
        end
    endtask

    task automatic test_contention();
        int n_rv0;
        int n_rv1;
        n_rv0 = 0;
        n_rv1 = 0;
        pulse_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 12'h010;
        addr1 = 12'h020;
        for (int i = 0; i < 24; i++) begin
            if (i == 20) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL contention_step%0d got flags=%b rdata=%h exp flags=%b rdata=%h",
                         i, {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
            if (i < 20) begin
                total++;
                if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
                    bad++;
                    $display("FAIL contention_alt%0d got gnt0=%b gnt1=%b exp gnt%0d", i, gnt0, gnt1, i % 2);
                end
            end
            if (rvalid0 === 1'b1) begin
                n_rv0++;
                total++;
                if (rdata !== 12'hA4A) begin
                    bad++;
                    $display("FAIL contention_data0 got=%h exp=A4A", rdata);
                end
            end
            if (rvalid1 === 1'b1) begin
                n_rv1++;
                total++;
                if (rdata !== 12'hA7A) begin
                    bad++;
                    $display("FAIL contention_data1 got=%h exp=A7A", rdata);
                end
            end
        end
        total++;
        if (n_rv0 != 10 || n_rv1 != 10) begin
            bad++;
            $display("FAIL contention_count got rv0=%0d rv1=%0d exp 10 10", n_rv0, n_rv1);
        end
    endtask

    task automatic test_late_drop();
        bit seen;
        int n_g;
        int n_rv;
        seen  = 1'b0;
        n_g   = 0;
        n_rv  = 0;
        req1  = 1'b1;
        addr1 = AW'($urandom_range(0, 4095));
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = gnt1;
            n_g += int'(gnt1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL late_drop_timeout got gnt1=0 exp gnt1=1 within 8 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req1 = 1'b0;
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL late_drop_step%0d got flags=%b rdata=%h exp flags=%b rdata=%h",
                         i, {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
            n_g  += int'(gnt1);
            n_rv += int'(rvalid1);
        end
        total++;
        if (n_g != 1 || n_rv != 1) begin
            bad++;
            $display("FAIL late_drop_count got gnt1=%0d rvalid1=%0d exp 1 1", n_g, n_rv);
        end
    endtask

    task automatic test_midflight_reset();
        bit seen;
        int n_rv1;
        seen  = 1'b0;
        n_rv1 = 0;
        req1  = 1'b1;
        addr1 = 12'h3C3;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = gnt1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midreset_timeout got gnt1=0 exp gnt1=1 within 8 cycles");
        end
        req1 = 1'b0;
        rst  = 1'b0;
        model_reset();
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, rdata, rom_addr} !== '0) begin
            bad++;
            $display("FAIL midreset_async got=%b_%b_%b_%b_%h_%h exp=all zero",
                     gnt0, gnt1, rvalid0, rvalid1, rdata, rom_addr);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            n_rv1 += int'(rvalid1);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_rv1 += int'(rvalid1);
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL midreset_idle%0d got flags=%b rdata=%h exp flags=%b rdata=%h",
                         i, {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
        end
        total++;
        if (n_rv1 != 0) begin
            bad++;
            $display("FAIL midreset_stale got rvalid1 pulses=%0d exp 0", n_rv1);
        end
        req0  = 1'b1;
        addr0 = 12'h055;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req0 = 1'b0;
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL midreset_resume%0d got flags=%b rdata=%h exp flags=%b rdata=%h",
                         i, {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if (!req0 || gnt0) begin
                req0  = 1'($urandom_range(0, 1));
                addr0 = AW'($urandom_range(0, 4095));
            end else if ($urandom_range(0, 15) == 0) begin
                req0 = 1'b0;
            end
            if (!req1 || gnt1) begin
                req1  = 1'($urandom_range(0, 1));
                addr1 = AW'($urandom_range(0, 4095));
            end else if ($urandom_range(0, 15) == 0) begin
                req1 = 1'b0;
            end
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL random_cyc%0d got flags=%b rdata=%h exp flags=%b rdata=%h",
                         cyc, {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) step();
    endtask

`ifdef ROM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        pulse_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 12'h0F0;
        addr1 = 12'h00F;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL fixed_pattern%0d got gnt0=%b gnt1=%b exp gnt%0d", i, gnt0, gnt1, i % 2);
            end
        end
        req0 = 1'b0;
        step();
        total++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL fixed_alone got gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
        end
        req1 = 1'b0;
        repeat (3) begin
            step();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags || rdata !== m_rdata) begin
                bad++;
                $display("FAIL fixed_drain got flags=%b rdata=%h exp flags=%b rdata=%h",
                         {gnt0, gnt1, rvalid0, rvalid1}, rdata, exp_flags, m_rdata);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_late_drop();
        test_midflight_reset();
        test_random();
`ifdef ROM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
